// File: rtl/regfile_wr_scoreboard.sv
// Writeback decoder and pending-write scoreboard for a 2**ADDR_W entry register file.
// Produces a registered one-hot write enable plus read-operand hazard and WAW flags.
module regfile_wr_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int ZERO_EN  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    output logic [(1<<ADDR_W)-1:0]  wr_sel,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_addr,
    input  logic [ADDR_W-1:0]       rd_addr_a,
    input  logic [ADDR_W-1:0]       rd_addr_b,
    output logic [(1<<ADDR_W)-1:0]  pend,
    output logic                    hazard_a,
    output logic                    hazard_b,
    output logic                    waw,
    output logic [ADDR_W:0]         pend_count
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [NREG-1:0] wr_sel_next;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] pend_next;

    // True when the address names the hardwired zero register and suppression is enabled.
    function automatic logic zsup(input logic [ADDR_W-1:0] addr);
        return (ZERO_EN != 0) && (addr == ZERO_ADDR);
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_sel_next = '0;
        clr_vec     = '0;
        set_vec     = '0;
        if (wr_en) begin
            clr_vec[wr_addr] = 1'b1;
            if (!zsup(wr_addr)) begin
                wr_sel_next[wr_addr] = 1'b1;
            end
        end
        if (iss_valid && !zsup(iss_addr)) begin
            set_vec[iss_addr] = 1'b1;
        end
    end

    // Set beats clear: a new producer issuing while the old one writes back stays outstanding.
    assign pend_next = set_vec | (pend & ~clr_vec);

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_sel <= '0;
            pend   <= '0;
        end else begin
            wr_sel <= wr_sel_next;
            pend   <= pend_next;
        end
    end

    // A same-cycle writeback bypasses the hazard: the regfile writes before it is read.
    assign hazard_a = pend[rd_addr_a] && !(wr_en && (wr_addr == rd_addr_a)) && !zsup(rd_addr_a);
    assign hazard_b = pend[rd_addr_b] && !(wr_en && (wr_addr == rd_addr_b)) && !zsup(rd_addr_b);
    assign waw      = iss_valid && pend[iss_addr] && !zsup(iss_addr)
                      && !(wr_en && (wr_addr == iss_addr));

    always_comb begin
        pend_count = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_count = pend_count + {{ADDR_W{1'b0}}, pend[i]};
        end
    end

endmodule

// File: tb/tb_regfile_wr_scoreboard.sv
// Directed bench for regfile_wr_scoreboard: one suppressing instance and one with
// the zero register treated as an ordinary register, both driven by the same inputs.
module tb_regfile_wr_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;

    logic [31:0] wr_sel,   nz_wr_sel;
    logic [31:0] pend,     nz_pend;
    logic        hazard_a, nz_hazard_a;
    logic        hazard_b, nz_hazard_b;
    logic        waw,      nz_waw;
    logic [5:0]  pend_count, nz_pend_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wr_scoreboard #(.ADDR_W(5), .ZERO_REG(31), .ZERO_EN(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b), .pend(pend), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .waw(waw), .pend_count(pend_count)
    );

    regfile_wr_scoreboard #(.ADDR_W(5), .ZERO_REG(31), .ZERO_EN(0)) dut_nz (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(nz_wr_sel),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b), .pend(nz_pend), .hazard_a(nz_hazard_a), .hazard_b(nz_hazard_b),
        .waw(nz_waw), .pend_count(nz_pend_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle so registered outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        wr_addr   = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
    endtask

    task automatic issue(input logic [4:0] a);
        iss_valid = 1'b1;
        iss_addr  = a;
        tick();
        idle();
    endtask

    task automatic wback(input logic [4:0] a);
        wr_en   = 1'b1;
        wr_addr = a;
        tick();
        idle();
    endtask

    initial begin
        logic [4:0] regs [8];
        regs = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd12, 5'd13, 5'd14, 5'd15};

        idle();
        rd_addr_a = '0;
        rd_addr_b = '0;
        reset     = 1'b1;
        tick();
        tick();
        check("rst_wr_sel", wr_sel, 0);
        check("rst_pend", pend, 0);
        check("rst_count", pend_count, 0);
        check("rst_haz_a", hazard_a, 0);
        check("rst_haz_b", hazard_b, 0);
        check("rst_waw", waw, 0);
        reset = 1'b0;

        // Decode latency and single-cycle pulse
        wr_en = 1'b1; wr_addr = 5'd5;
        tick();
        check("dec5", wr_sel, 32'h0000_0020);
        idle();
        tick();
        check("dec5_off", wr_sel, 0);

        for (int a = 0; a <= 30; a++) begin
            wr_en = 1'b1; wr_addr = 5'(a);
            tick();
            check($sformatf("sweep%0d", a), wr_sel, 32'h1 << a);
        end
        idle();
        tick();
        check("sweep_off", wr_sel, 0);

        // Zero register suppression vs. ordinary register
        wr_en = 1'b1; wr_addr = 5'd31;
        tick();
        check("zr_wr_sel", wr_sel, 0);
        check("nz_wr_sel", nz_wr_sel, 32'h8000_0000);
        idle();
        iss_valid = 1'b1; iss_addr = 5'd31; rd_addr_a = 5'd31;
        tick();
        idle();
        check("zr_pend", pend, 0);
        check("nz_pend31", nz_pend, 32'h8000_0000);
        check("zr_haz_a", hazard_a, 0);
        check("nz_haz_a", nz_hazard_a, 1);
        iss_valid = 1'b1; iss_addr = 5'd31;
        #1;
        check("zr_waw", waw, 0);
        check("nz_waw", nz_waw, 1);
        idle();
        wback(5'd31);
        check("nz_pend_clr", nz_pend, 0);
        rd_addr_a = '0;

        // Scoreboard set, hazard, bypass, clear
        iss_valid = 1'b1; iss_addr = 5'd3; rd_addr_a = 5'd3;
        #1;
        check("haz_same_issue", hazard_a, 0);
        tick();
        idle();
        check("pend_x3", pend, 32'h8);
        check("count_x3", pend_count, 1);
        check("haz_a_x3", hazard_a, 1);
        wr_en = 1'b1; wr_addr = 5'd3;
        #1;
        check("haz_bypass", hazard_a, 0);
        tick();
        idle();
        check("pend_x3_clr", pend, 0);
        check("wr_sel_x3", wr_sel, 32'h8);
        rd_addr_a = '0;

        // Simultaneous issue and writeback
        issue(5'd7);
        check("pend_x7", pend, 32'h80);
        iss_valid = 1'b1; iss_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7;
        tick();
        idle();
        check("set_wins", pend, 32'h80);
        iss_valid = 1'b1; iss_addr = 5'd2; wr_en = 1'b1; wr_addr = 5'd7;
        tick();
        idle();
        check("both_effect", pend, 32'h4);
        check("both_count", pend_count, 1);
        wback(5'd2);
        wback(5'd2);
        check("clr_noop", pend, 0);

        // WAW detection and bypass
        issue(5'd9);
        iss_valid = 1'b1; iss_addr = 5'd9;
        #1;
        check("waw_set", waw, 1);
        wr_en = 1'b1; wr_addr = 5'd9;
        #1;
        check("waw_bypass", waw, 0);
        wr_en = 1'b0;
        tick();
        idle();
        check("waw_pend_kept", pend, 32'h200);
        wback(5'd9);
        check("waw_pend_clr", pend, 0);

        // Reset mid-run discards same-cycle issue and writeback
        foreach (regs[k]) issue(regs[k]);
        check("pend_f0f0", pend, 32'h0000_F0F0);
        check("count_f0f0", pend_count, 8);
        rd_addr_b = 5'd12;
        #1;
        check("haz_b_12", hazard_b, 1);
        rd_addr_b = 5'd11;
        #1;
        check("haz_b_11", hazard_b, 0);
        iss_valid = 1'b1; iss_addr = 5'd0; wr_en = 1'b1; wr_addr = 5'd4; reset = 1'b1;
        tick();
        idle();
        reset = 1'b0;
        check("mid_rst_pend", pend, 0);
        check("mid_rst_count", pend_count, 0);
        check("mid_rst_wr_sel", wr_sel, 0);
        tick();
        check("post_rst_wr_sel", wr_sel, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
